adc_req_arbiter: RTL and testbench



---
 rtl/adc_req_arbiter_pkg.sv | 35 +++
 rtl/adc_req_arbiter_if.sv | 28 ++
 rtl/adc_req_arbiter_rr_pick.sv | 35 +++
 rtl/adc_req_arbiter.sv | 126 ++++++++++++
 tb/tb_adc_req_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_req_arbiter_pkg.sv
// Shared definitions for the ADC request arbiter: FSM encoding, data width
// of the serial ADC front-end, and a constant-width helper.
package adc_req_arbiter_pkg;

   localparam int ADC_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_DELIVER = 3'd3,
      ST_GAP     = 3'd4
   } state_t;

   // Bits needed to hold values 0..value-1; never less than one bit so that
   // degenerate parameters (e.g. MIN_GAP=0) still give a legal vector.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      if (r < 1) begin
         r = 1;
      end else begin
         r = r;
      end
      return r;
   endfunction

endpackage

// File: rtl/adc_req_arbiter_if.sv
// Bundle of requester handshake and ADC front-end signals around the arbiter.
// The arbiter uses the slave view; the system / bench uses the master view.
interface adc_req_arbiter_if
   import adc_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = ADC_DATA_W
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] ack;
   logic [DATA_W-1:0]  rd_data;
   logic               rd_err;
   logic               busy;
   logic [2:0]         owner;
   logic               conv_start;
   logic               conv_done;
   logic [DATA_W-1:0]  conv_data;

   modport slave (
      input  req, conv_done, conv_data,
      output ack, rd_data, rd_err, busy, owner, conv_start
   );

   modport master (
      output req, conv_done, conv_data,
      input  ack, rd_data, rd_err, busy, owner, conv_start
   );
endinterface

// File: rtl/adc_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester set when scanning
// upward from last_grant+1 with wrap-around.
module adc_rr_pick
   import adc_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         last_grant,
   output logic [2:0]         grant,
   output logic               any_req
);
   int   pos;
   logic found;
   logic hit;

   // Scan all requesters once, starting just after the previous winner.
   always_comb begin
      grant   = 3'd0;
      any_req = |req;
      found   = 1'b0;
      pos     = 0;
      hit     = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         pos = (int'(last_grant) + i) % NUM_REQ;
         hit = |(req & (NUM_REQ'(1) << pos));
         if (!found && hit) begin
            grant = 3'(pos);
            found = 1'b1;
         end else begin
            grant = grant;
         end
      end
   end
endmodule

// File: rtl/adc_req_arbiter.sv
// Round-robin arbiter sharing one serial ADC front-end among NUM_REQ
// requesters. Sequences start / wait-for-done / deliver / recovery gap and
// abandons a conversion after TIMEOUT cycles.
module adc_req_arbiter
   import adc_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = ADC_DATA_W,
   parameter int MIN_GAP = 16,
   parameter int TIMEOUT = 4096
)(
   input logic              clk,
   input logic              rstn,
   adc_req_arbiter_if.slave bus
);
   localparam int TMO_W = clog2(TIMEOUT);
   localparam int GAP_W = clog2(MIN_GAP + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

   state_t           state;
   logic [TMO_W-1:0] tmo_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [2:0]       last_grant;
   logic             done_sync1;
   logic             done_sync2;
   logic             done_prev;
   logic             done_rise;
   logic [2:0]       pick_idx;
   logic             pick_any;

   adc_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req        (bus.req),
      .last_grant (last_grant),
      .grant      (pick_idx),
      .any_req    (pick_any)
   );

   // Bring the slow asynchronous done level into clk and keep its last value.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done_sync1 <= 1'b0;
         done_sync2 <= 1'b0;
         done_prev  <= 1'b0;
      end else begin
         done_sync1 <= bus.conv_done;
         done_sync2 <= done_sync1;
         done_prev  <= done_sync2;
      end
   end

   // Only a fresh rise counts, so a level already high entering WAIT is stale.
   assign done_rise = done_sync2 & ~done_prev;

   // Conversion sequencer with all outputs registered.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= ST_IDLE;
         tmo_cnt        <= '0;
         gap_cnt        <= '0;
         last_grant     <= 3'(NUM_REQ - 1);
         bus.ack        <= '0;
         bus.rd_data    <= '0;
         bus.rd_err     <= 1'b0;
         bus.busy       <= 1'b0;
         bus.owner      <= 3'd0;
         bus.conv_start <= 1'b0;
      end else begin
         bus.ack        <= '0;
         bus.conv_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  bus.owner <= pick_idx;
                  bus.busy  <= 1'b1;
                  state     <= ST_START;
               end else begin
                  bus.busy  <= 1'b0;
               end
            end
            ST_START: begin
               bus.conv_start <= 1'b1;
               tmo_cnt        <= '0;
               state          <= ST_WAIT;
            end
            ST_WAIT: begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
               if (done_rise) begin
                  bus.rd_data <= bus.conv_data;
                  bus.rd_err  <= 1'b0;
                  state       <= ST_DELIVER;
               end else if (tmo_cnt == TMO_LAST) begin
                  bus.rd_err  <= 1'b1;
                  state       <= ST_DELIVER;
               end else begin
                  state       <= ST_WAIT;
               end
            end
            ST_DELIVER: begin
               bus.ack    <= NUM_REQ'(1) << bus.owner;
               last_grant <= bus.owner;
               gap_cnt    <= GAP_LOAD;
               if (MIN_GAP == 0) begin
                  bus.busy <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  state    <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt <= GAP_W'(1)) begin
                  gap_cnt  <= '0;
                  bus.busy <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  gap_cnt  <= gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_adc_req_arbiter.sv
// Self-checking bench for adc_req_arbiter: selector vector table, directed
// corner sequences, and randomized conversions against a round-robin model.
module tb_adc_req_arbiter;
   import adc_req_arbiter_pkg::*;

   localparam int NR      = 4;
   localparam int DW      = 8;
   localparam int MIN_GAP = 5;
   localparam int TIMEOUT = 64;

   logic clk;
   logic rstn;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   adc_req_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

   adc_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Stand-alone selector for table-driven checks.
   logic [NR-1:0] pk_req;
   logic [2:0]    pk_last;
   logic [2:0]    pk_grant;
   logic          pk_any;
   adc_rr_pick #(.NUM_REQ(NR)) u_pk (
      .req (pk_req), .last_grant (pk_last), .grant (pk_grant), .any_req (pk_any)
   );

   // Front-end model: automatic responder or manual drive.
   bit            fe_en = 1'b1;
   int            fe_dly = 2;
   logic [DW-1:0] fe_data = '0;
   logic          fe_done = 1'b0;
   logic [DW-1:0] fe_dout = '0;
   logic          man_done = 1'b0;
   logic [DW-1:0] man_data = '0;
   int            done_cyc = 0;
   assign bus.conv_done = fe_en ? fe_done : man_done;
   assign bus.conv_data = fe_en ? fe_dout : man_data;

   // Monitor results
   int            start_cnt = 0, start_cyc = 0, prev_start_cyc = 0;
   int            ack_cnt = 0, ack_cyc = 0;
   logic [NR-1:0] ack_val = '0;
   logic [DW-1:0] ack_data = '0;
   logic          ack_err = 1'b0;
   logic [2:0]    ack_owner = '0;
   int            exp_last = NR - 1;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: requester with the smallest forward distance from last winner.
   function automatic int rr_expect(input logic [NR-1:0] r, input int last);
      int best, bestd, d;
      best = -1; bestd = NR + 1;
      for (int k = 0; k < NR; k++) begin
         d = (k - last - 1 + 2 * NR) % NR;
         if (r[k] && d < bestd) begin
            bestd = d; best = k;
         end
      end
      return best;
   endfunction

   initial begin
      forever begin
         @(posedge clk); #1;
         if (bus.conv_start === 1'b1) begin
            prev_start_cyc = start_cyc; start_cyc = cyc; start_cnt++;
         end
         if (bus.ack !== '0) begin
            chk("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
            ack_cnt++; ack_val = bus.ack; ack_data = bus.rd_data;
            ack_err = bus.rd_err; ack_owner = bus.owner; ack_cyc = cyc;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #2;
         if (fe_en && bus.conv_start === 1'b1) begin
            repeat (fe_dly) begin @(posedge clk); #2; end
            fe_dout = fe_data; fe_done = 1'b1; done_cyc = cyc;
            repeat (4) begin @(posedge clk); #2; end
            fe_done = 1'b0;
         end
      end
   end

   task automatic wait_ack(input string name, input int c0);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (ack_cnt != c0) ok = 1'b1;
      end
      if (!ok) chk({name, "_ack_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_start(input string name, input int c0);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (start_cnt != c0) ok = 1'b1;
      end
      if (!ok) chk({name, "_start_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) ok = 1'b1;
      end
      if (!ok) chk({name, "_idle_timeout"}, 32'd0, 32'd1);
   endtask

   // One full conversion with the auto front-end; req dropped after ack.
   task automatic run_conv(input string name, input logic [NR-1:0] rq, input logic [DW-1:0] d,
                           input int dly, input bit drop_early);
      int a0, s0;
      a0 = ack_cnt; s0 = start_cnt;
      fe_data = d; fe_dly = dly;
      bus.req = rq;
      if (drop_early) begin
         wait_start(name, s0);
         bus.req = '0;
      end
      wait_ack(name, a0);
      bus.req = '0;
      wait_idle(name);
   endtask

   typedef struct {
      logic [NR-1:0] req;
      logic [2:0]    last;
      logic [2:0]    grant;
      logic          any;
   } pick_vec_t;

   typedef struct {
      logic [NR-1:0] req;
      logic [DW-1:0] data;
      int            dly;
      logic [NR-1:0] exp_ack;
   } conv_vec_t;

   pick_vec_t pv[12];
   conv_vec_t cv[6];

   initial begin
      int a0, s0, t0, exp;
      logic [NR-1:0] rq, prev;
      logic [DW-1:0] d;
      pv[0]  = '{4'b0000, 3'd3, 3'd0, 1'b0};
      pv[1]  = '{4'b0001, 3'd3, 3'd0, 1'b1};
      pv[2]  = '{4'b1111, 3'd3, 3'd0, 1'b1};
      pv[3]  = '{4'b1111, 3'd0, 3'd1, 1'b1};
      pv[4]  = '{4'b1111, 3'd2, 3'd3, 1'b1};
      pv[5]  = '{4'b1010, 3'd0, 3'd1, 1'b1};
      pv[6]  = '{4'b1010, 3'd1, 3'd3, 1'b1};
      pv[7]  = '{4'b1010, 3'd3, 3'd1, 1'b1};
      pv[8]  = '{4'b0100, 3'd2, 3'd2, 1'b1};
      pv[9]  = '{4'b1001, 3'd0, 3'd3, 1'b1};
      pv[10] = '{4'b1000, 3'd1, 3'd3, 1'b1};
      pv[11] = '{4'b0110, 3'd2, 3'd1, 1'b1};
      cv[0] = '{4'b0100, 8'h3C, 2, 4'b0100};
      cv[1] = '{4'b1001, 8'hC3, 5, 4'b1000};
      cv[2] = '{4'b0011, 8'h5A, 1, 4'b0001};
      cv[3] = '{4'b0011, 8'h77, 0, 4'b0010};
      cv[4] = '{4'b1111, 8'hE1, 3, 4'b0100};
      cv[5] = '{4'b0001, 8'h0F, 6, 4'b0001};

      bus.req = '0; pk_req = '0; pk_last = '0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
      chk("rst_rd_err", 32'(bus.rd_err), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
      chk("rst_conv_start", 32'(bus.conv_start), 32'd0);
      rstn = 1'b1;

      // Selector vector table.
      for (int i = 0; i < 12; i++) begin
         pk_req = pv[i].req; pk_last = pv[i].last;
         #1;
         chk($sformatf("pick_grant_%0d", i), 32'(pk_grant), 32'(pv[i].grant));
         chk($sformatf("pick_any_%0d", i), 32'(pk_any), 32'(pv[i].any));
      end

      // Idle with no requests: no conversion starts.
      repeat (10) @(negedge clk);
      chk("idle_no_start", 32'(start_cnt), 32'd0);

      // Single request, latency checks.
      a0 = ack_cnt; s0 = start_cnt;
      fe_data = 8'hA5; fe_dly = 3;
      bus.req = 4'b0001; t0 = cyc;
      wait_ack("single", a0);
      bus.req = '0;
      chk("single_req_to_start", 32'(start_cyc - t0), 32'd2);
      chk("single_done_to_ack", 32'(ack_cyc - done_cyc), 32'd4);
      chk("single_ack", 32'(ack_val), 32'h1);
      chk("single_data", 32'(ack_data), 32'hA5);
      chk("single_err", 32'(ack_err), 32'd0);
      chk("single_owner", 32'(ack_owner), 32'd0);
      wait_idle("single");
      repeat (MIN_GAP + 10) @(negedge clk);
      chk("single_one_start", 32'(start_cnt - s0), 32'd1);
      exp_last = 0;

      // Table of single conversions.
      for (int i = 0; i < 6; i++) begin
         a0 = ack_cnt;
         run_conv($sformatf("tab%0d", i), cv[i].req, cv[i].data, cv[i].dly, 1'b0);
         chk($sformatf("tab_ack_%0d", i), 32'(ack_val), 32'(cv[i].exp_ack));
         chk($sformatf("tab_data_%0d", i), 32'(ack_data), 32'(cv[i].data));
         chk($sformatf("tab_err_%0d", i), 32'(ack_err), 32'd0);
      end
      exp_last = 0;

      // Timeout: front-end never answers.
      fe_en = 1'b0; man_done = 1'b0;
      a0 = ack_cnt;
      bus.req = 4'b1000;
      wait_ack("timeout", a0);
      bus.req = '0;
      chk("timeout_latency", 32'(ack_cyc - start_cyc), 32'd65);
      chk("timeout_err", 32'(ack_err), 32'd1);
      chk("timeout_data_kept", 32'(ack_data), 32'h0F);
      chk("timeout_ack", 32'(ack_val), 32'h8);
      wait_idle("timeout");
      fe_en = 1'b1;
      run_conv("after_timeout", 4'b0010, 8'h42, 2, 1'b0);
      chk("after_timeout_ack", 32'(ack_val), 32'h2);
      chk("after_timeout_data", 32'(ack_data), 32'h42);
      chk("after_timeout_err", 32'(ack_err), 32'd0);

      // Stale done level present before the conversion starts.
      fe_en = 1'b0; man_data = 8'hBB; man_done = 1'b1;
      repeat (5) @(negedge clk);
      a0 = ack_cnt; s0 = start_cnt;
      bus.req = 4'b0001;
      wait_start("stale", s0);
      repeat (10) @(negedge clk);
      chk("stale_no_ack", 32'(ack_cnt - a0), 32'd0);
      chk("stale_busy", 32'(bus.busy), 32'd1);
      man_done = 1'b0;
      repeat (3) @(negedge clk);
      man_data = 8'h3E; man_done = 1'b1; done_cyc = cyc;
      wait_ack("stale", a0);
      bus.req = '0;
      chk("stale_ack", 32'(ack_val), 32'h1);
      chk("stale_data", 32'(ack_data), 32'h3E);
      chk("stale_done_to_ack", 32'(ack_cyc - done_cyc), 32'd4);
      repeat (2) @(negedge clk);
      man_done = 1'b0;
      wait_idle("stale");

      // Reset in the middle of WAIT.
      s0 = start_cnt;
      bus.req = 4'b0010;
      wait_start("rstwait", s0);
      repeat (3) @(negedge clk);
      rstn = 1'b0; bus.req = '0;
      repeat (2) @(negedge clk);
      chk("rstw_ack", 32'(bus.ack), 32'd0);
      chk("rstw_rd_data", 32'(bus.rd_data), 32'd0);
      chk("rstw_rd_err", 32'(bus.rd_err), 32'd0);
      chk("rstw_busy", 32'(bus.busy), 32'd0);
      chk("rstw_owner", 32'(bus.owner), 32'd0);
      rstn = 1'b1;
      a0 = ack_cnt;
      man_data = 8'h99; man_done = 1'b1;
      repeat (4) @(negedge clk);
      man_done = 1'b0;
      repeat (8) @(negedge clk);
      chk("rstw_no_ack", 32'(ack_cnt - a0), 32'd0);
      chk("rstw_idle", 32'(bus.busy), 32'd0);
      fe_en = 1'b1;
      run_conv("rstw_next", 4'b1111, 8'h11, 1, 1'b0);
      chk("rstw_next_ack", 32'(ack_val), 32'h1);
      exp_last = 0;

      // Contention: 1 and 3 request, each drops after its own ack.
      fe_data = 8'h6D; fe_dly = 2;
      rq = 4'b1010;
      bus.req = rq;
      for (int i = 0; i < 2; i++) begin
         a0 = ack_cnt;
         wait_ack("contention", a0);
         rq = rq & ~ack_val;
         bus.req = rq;
         chk($sformatf("contention_ack_%0d", i), 32'(ack_val), (i == 0) ? 32'h2 : 32'h8);
      end
      chk("contention_gap", 32'((start_cyc - prev_start_cyc) >= (MIN_GAP + 3)), 32'd1);
      wait_idle("contention");
      exp_last = 3;

      // Fairness: all four held through eight conversions.
      bus.req = 4'b1111; prev = '0;
      for (int i = 0; i < 8; i++) begin
         a0 = ack_cnt;
         fe_data = 8'(i * 17); fe_dly = i % 3;
         wait_ack("fair", a0);
         chk($sformatf("fair_ack_%0d", i), 32'(ack_val), 32'(1 << (i % NR)));
         chk($sformatf("fair_norepeat_%0d", i), 32'(ack_val != prev), 32'd1);
         prev = ack_val;
      end
      bus.req = '0;
      wait_idle("fair");
      exp_last = 3;

      // Randomized conversions against the round-robin model.
      for (int i = 0; i < 24; i++) begin
         rq = 4'($urandom_range(1, 15));
         d = 8'($urandom);
         exp = rr_expect(rq, exp_last);
         run_conv($sformatf("rnd%0d", i), rq, d, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
         chk($sformatf("rnd_ack_%0d", i), 32'(ack_val), 32'(1 << exp));
         chk($sformatf("rnd_data_%0d", i), 32'(ack_data), 32'(d));
         chk($sformatf("rnd_err_%0d", i), 32'(ack_err), 32'd0);
         exp_last = exp;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
